up_dn_counter_param: RTL and testbench
======================================

// Module: up_dn_counter_param
// PURPOSE
//  Parametrised up/down counter: programmable width, bounds and step size.
//  Selectable saturate or wrap at the bounds, and registered terminal-count pulses.
//  Next-generation replacement for the fixed 5-bit load/up/down counter.
//  Used as a loadable event/position counter inside control datapaths.
// PARAMETERS
//  WIDTH      8             counter width in bits (>=2)
//  MIN_VAL    0             lower bound, inclusive (MIN_VAL < MAX_VAL)
//  MAX_VAL    2**WIDTH-1    upper bound, inclusive (<= 2**WIDTH-1)
//  RESET_VAL  0             value after reset (MIN_VAL..MAX_VAL)
//  STEP_W     4             width of Step input
// PORTS
//  CLK      in   1        clock, rising edge
//  RST_n    in   1        asynchronous active-low reset
//  En       in   1        count enable; gates Up/Down only, not Load
//  Up       in   1        count up by Step
//  Down     in   1        count down by Step
//  Load     in   1        load IN (highest priority)
//  IN       in   WIDTH    load value
//  Step     in   STEP_W   increment magnitude; 0 = hold
//  Wrap     in   1        1 = wrap at bounds, 0 = saturate
//  Counter  out  WIDTH    registered count
//  High     out  1        Counter == MAX_VAL (combinational from Counter)
//  Low      out  1        Counter == MIN_VAL (combinational from Counter)
//  Tc_Up    out  1        1-cycle registered pulse: up-count hit/crossed MAX_VAL
//  Tc_Dn    out  1        1-cycle registered pulse: down-count hit/crossed MIN_VAL
// BEHAVIOUR
//  - Reset (RST_n=0, asynchronous): Counter=RESET_VAL, Tc_Up=0, Tc_Dn=0.
//  - Operation priority per cycle: Load > (En&Down) > (En&Up) > hold.
//    Up and Down both asserted means Down.
//  - Load: Counter <= IN clamped to [MIN_VAL,MAX_VAL]. No Tc pulse.
//  - Latency: one clock; Counter updates on the edge after inputs are sampled.
//  - All arithmetic is done in WIDTH+1 bits; Step is zero-extended.
//  - Up, nxt = Counter+Step:
//    - nxt <= MAX_VAL: Counter <= nxt.
//    - nxt >  MAX_VAL: Wrap=0 gives MAX_VAL; Wrap=1 gives MIN_VAL (wrap reloads the bound; no residue carried).
//    - Tc_Up=1 iff Step!=0 and nxt >= MAX_VAL.
//  - Down, nxt = Counter-Step (signed WIDTH+1):
//    - nxt >= MIN_VAL: Counter <= nxt.
//    - nxt <  MIN_VAL: Wrap=0 gives MIN_VAL; Wrap=1 gives MAX_VAL.
//    - Tc_Dn=1 iff Step!=0 and nxt <= MIN_VAL.
//  - Saturated hold at a bound with further counting still pulses Tc each cycle.
//  - Tc_Up and Tc_Dn are never both 1; both are 0 on any hold or Load cycle.
//  - Wrap and Step are sampled per cycle and may change at any time.
//  - Reset asserted mid-count: outputs return to reset values immediately.
//    Counting resumes on the first edge after deassertion.
// CONFIGURATION
//  UDC_WRAP_CNT_EN defined:
//    Adds port Wrap_Cnt out 8: count of wrap events (a Wrap=1 bound crossing).
//    Saturates at 255; cleared by reset and by Load. Updates in the same cycle as Counter.
//  UDC_WRAP_CNT_EN undefined:
//    Port and logic are absent; all other behaviour is identical.
// TESTING (WIDTH=8, MIN_VAL=10, MAX_VAL=200, RESET_VAL=10, STEP_W=4)
//  - Reset: RST_n=0 mid-count at 57 -> Counter=10, Low=1, Tc_Up=Tc_Dn=0 without waiting for a clock edge.
//  - Load: Load=1, IN=5 -> 10; IN=250 -> 200 with High=1; Load with En=0 still loads.
//  - Saturate: Counter=195, Up, Step=7, Wrap=0 -> 200, Tc_Up=1; next Up -> 200, Tc_Up=1.
//  - Wrap: Counter=12, Down, Step=5, Wrap=1 -> 200, Tc_Dn=1; Wrap_Cnt 0->1 if enabled.
//  - Priority: Up=Down=1, Step=3 at 100 -> 97; Load=1 with Up=1 -> IN; Step=0 -> hold, no Tc.
//  - Enable: En=0, Up=1 for 5 cycles -> Counter unchanged and no Tc pulses.

Source files
------------

// File: rtl/up_dn_counter_param.sv
// ---------------------------------------------------------------------------
// up_dn_counter_param
//
// Loadable up/down counter for control datapaths. Width, bounds, reset value
// and step width are set by parameters. At a bound the counter either
// saturates or wraps to the opposite bound, chosen per cycle by Wrap.
// Terminal-count pulses are registered and last one cycle.
//
// Optional feature: define UDC_WRAP_CNT_EN to add Wrap_Cnt, an 8-bit
// saturating count of wrap events. Reset and Load clear it.
//
// Ports
//   CLK       in   1        clock, rising edge
//   RST_n     in   1        asynchronous active-low reset
//   En        in   1        count enable (gates Up/Down, not Load)
//   Up        in   1        count up by Step
//   Down      in   1        count down by Step (wins over Up)
//   Load      in   1        load IN, clamped to [MIN_VAL,MAX_VAL] (highest priority)
//   IN        in   WIDTH    load value
//   Step      in   STEP_W   step magnitude, 0 = hold
//   Wrap      in   1        1 = wrap at bounds, 0 = saturate
//   Counter   out  WIDTH    registered count
//   High      out  1        Counter == MAX_VAL
//   Low       out  1        Counter == MIN_VAL
//   Tc_Up     out  1        registered pulse: up-count reached/crossed MAX_VAL
//   Tc_Dn     out  1        registered pulse: down-count reached/crossed MIN_VAL
//   Wrap_Cnt  out  8        wrap event count (UDC_WRAP_CNT_EN only)
// ---------------------------------------------------------------------------
module up_dn_counter_param #(
    parameter int WIDTH     = 8,
    parameter int MIN_VAL   = 0,
    parameter int MAX_VAL   = 2**WIDTH-1,
    parameter int RESET_VAL = 0,
    parameter int STEP_W    = 4
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              En,
    input  logic              Up,
    input  logic              Down,
    input  logic              Load,
    input  logic [WIDTH-1:0]  IN,
    input  logic [STEP_W-1:0] Step,
    input  logic              Wrap,
    output logic [WIDTH-1:0]  Counter,
    output logic              High,
    output logic              Low,
    output logic              Tc_Up,
    output logic              Tc_Dn
`ifdef UDC_WRAP_CNT_EN
    ,
    output logic [7:0]        Wrap_Cnt
`endif
);

    localparam int EW = WIDTH + 1;

    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MIN_E = EW'(MIN_VAL);
    localparam logic [WIDTH:0]   MAX_E = EW'(MAX_VAL);

    // One extra bit of headroom: the up sum cannot overflow, and the down
    // difference is read as signed so an underflow below zero is negative.
    logic [WIDTH:0]   cnt_e;
    logic [WIDTH:0]   step_e;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_diff;
    logic             step_nz;
    logic             up_over;
    logic             up_tc;
    logic             dn_under;
    logic             dn_tc;
    logic [WIDTH-1:0] load_val;

    assign cnt_e    = {1'b0, Counter};
    assign step_e   = EW'(Step);
    assign up_sum   = cnt_e + step_e;
    assign dn_diff  = cnt_e - step_e;
    assign step_nz  = |Step;
    assign up_over  = up_sum > MAX_E;
    assign up_tc    = step_nz && (up_sum >= MAX_E);
    assign dn_under = $signed(dn_diff) < $signed(MIN_E);
    assign dn_tc    = step_nz && ($signed(dn_diff) <= $signed(MIN_E));

    always_comb begin
        load_val = IN;
        if (IN < MIN_W) begin
            load_val = MIN_W;
        end else if (IN > MAX_W) begin
            load_val = MAX_W;
        end
    end

    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_up_nxt;
    logic             tc_dn_nxt;
    logic             wrap_evt;

    // Priority: Load > En&Down > En&Up > hold. Wrapping reloads the opposite
    // bound; any residue beyond the bound is discarded.
    always_comb begin
        cnt_nxt   = Counter;
        tc_up_nxt = 1'b0;
        tc_dn_nxt = 1'b0;
        wrap_evt  = 1'b0;
        if (Load) begin
            cnt_nxt = load_val;
        end else if (En && Down) begin
            tc_dn_nxt = dn_tc;
            if (dn_under) begin
                cnt_nxt  = Wrap ? MAX_W : MIN_W;
                wrap_evt = Wrap;
            end else begin
                cnt_nxt = dn_diff[WIDTH-1:0];
            end
        end else if (En && Up) begin
            tc_up_nxt = up_tc;
            if (up_over) begin
                cnt_nxt  = Wrap ? MIN_W : MAX_W;
                wrap_evt = Wrap;
            end else begin
                cnt_nxt = up_sum[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Counter <= RST_W;
            Tc_Up   <= 1'b0;
            Tc_Dn   <= 1'b0;
        end else begin
            Counter <= cnt_nxt;
            Tc_Up   <= tc_up_nxt;
            Tc_Dn   <= tc_dn_nxt;
        end
    end

    assign High = (Counter == MAX_W);
    assign Low  = (Counter == MIN_W);

`ifdef UDC_WRAP_CNT_EN
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Wrap_Cnt <= 8'd0;
        end else if (Load) begin
            Wrap_Cnt <= 8'd0;
        end else if (wrap_evt && (Wrap_Cnt != 8'hFF)) begin
            Wrap_Cnt <= Wrap_Cnt + 8'd1;
        end
    end
`else
    logic unused_wrap_evt;
    assign unused_wrap_evt = wrap_evt;
`endif

endmodule

// File: tb/tb_up_dn_counter_param.sv
// ---------------------------------------------------------------------------
// tb_up_dn_counter_param
//
// Bench for up_dn_counter_param with WIDTH=8, MIN_VAL=10, MAX_VAL=200,
// RESET_VAL=10, STEP_W=4. A vector table walks load clamping, priority,
// saturation, wrapping and terminal counts; hand-written sequences cover
// the enable gate and asynchronous reset. Define UDC_WRAP_CNT_EN to also
// check Wrap_Cnt.
// ---------------------------------------------------------------------------
module tb_up_dn_counter_param;

    localparam int MIN_V = 10;
    localparam int MAX_V = 200;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       En = 1'b0;
    logic       Up = 1'b0;
    logic       Down = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] IN = 8'd0;
    logic [3:0] Step = 4'd0;
    logic       Wrap = 1'b0;
    logic [7:0] Counter;
    logic       High;
    logic       Low;
    logic       Tc_Up;
    logic       Tc_Dn;
`ifdef UDC_WRAP_CNT_EN
    logic [7:0] Wrap_Cnt;
`endif

    always #5 CLK = ~CLK;

    up_dn_counter_param #(
        .WIDTH(8), .MIN_VAL(MIN_V), .MAX_VAL(MAX_V), .RESET_VAL(10), .STEP_W(4)
    ) dut (
        .CLK(CLK), .RST_n(RST_n), .En(En), .Up(Up), .Down(Down), .Load(Load),
        .IN(IN), .Step(Step), .Wrap(Wrap), .Counter(Counter), .High(High),
        .Low(Low), .Tc_Up(Tc_Up), .Tc_Dn(Tc_Dn)
`ifdef UDC_WRAP_CNT_EN
        , .Wrap_Cnt(Wrap_Cnt)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];   // {cnt, high, low, tc_up, tc_dn}
    logic [7:0]  wc_q[$];

    task automatic expect_out(input logic [7:0] cnt, input logic tu, input logic td,
                              input logic [7:0] wc);
        exp_q.push_back({cnt, (cnt == 8'(MAX_V)), (cnt == 8'(MIN_V)), tu, td});
        wc_q.push_back(wc);
    endtask

    task automatic check(input string name);
        logic [11:0] e;
        logic [11:0] a;
        logic [7:0]  ewc;
        n_checks++;
        if (exp_q.size() == 0 || wc_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e   = exp_q.pop_front();
            ewc = wc_q.pop_front();
            a   = {Counter, High, Low, Tc_Up, Tc_Dn};
            if (a !== e) begin
                n_errors++;
                $display("FAIL %s got cnt=%0d high=%0b low=%0b tc_up=%0b tc_dn=%0b want cnt=%0d high=%0b low=%0b tc_up=%0b tc_dn=%0b",
                         name, a[11:4], a[3], a[2], a[1], a[0], e[11:4], e[3], e[2], e[1], e[0]);
            end
`ifdef UDC_WRAP_CNT_EN
            n_checks++;
            if (Wrap_Cnt !== ewc) begin
                n_errors++;
                $display("FAIL %s_wrap_cnt got %0d want %0d", name, Wrap_Cnt, ewc);
            end
`else
            if (ewc === 8'hxx) n_errors = n_errors;
`endif
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic ld, input logic en, input logic up, input logic dn,
                         input logic [7:0] in_v, input logic [3:0] st, input logic wr);
        Load = ld; En = en; Up = up; Down = dn; IN = in_v; Step = st; Wrap = wr;
    endtask

    // Inputs change on the falling edge; outputs are checked on the next one.
    task automatic cycle(input string name);
        @(posedge CLK);
        @(negedge CLK);
        check(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       ld, en, up, dn;
        logic [7:0] in_v;
        logic [3:0] st;
        logic       wr;
        logic [7:0] e_cnt;
        logic       e_tu, e_td;
        logic [7:0] e_wc;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(input string n, input logic ld, input logic en,
                                input logic up, input logic dn, input logic [7:0] in_v,
                                input logic [3:0] st, input logic wr, input logic [7:0] ec,
                                input logic etu, input logic etd, input logic [7:0] ewc);
        vec_t v;
        v.name = n; v.ld = ld; v.en = en; v.up = up; v.dn = dn; v.in_v = in_v;
        v.st = st; v.wr = wr; v.e_cnt = ec; v.e_tu = etu; v.e_td = etd; v.e_wc = ewc;
        return v;
    endfunction

    initial begin
        //              name               ld en up dn  in  st  wr  cnt  tu td wc
        vecs[0]  = mk("load_clamp_lo",    1, 1, 0, 0,   5,  0, 0,  10, 0, 0, 0);
        vecs[1]  = mk("load_clamp_hi",    1, 1, 0, 0, 250,  0, 0, 200, 0, 0, 0);
        vecs[2]  = mk("load_en0",         1, 0, 0, 0,  57,  0, 0,  57, 0, 0, 0);
        vecs[3]  = mk("up_step3",         0, 1, 1, 0,   0,  3, 0,  60, 0, 0, 0);
        vecs[4]  = mk("dn_step5",         0, 1, 0, 1,   0,  5, 0,  55, 0, 0, 0);
        vecs[5]  = mk("load_100",         1, 0, 0, 0, 100,  0, 0, 100, 0, 0, 0);
        vecs[6]  = mk("up_dn_both",       0, 1, 1, 1,   0,  3, 0,  97, 0, 0, 0);
        vecs[7]  = mk("load_over_up",     1, 1, 1, 0, 150,  3, 0, 150, 0, 0, 0);
        vecs[8]  = mk("step0_hold",       0, 1, 1, 0,   0,  0, 0, 150, 0, 0, 0);
        vecs[9]  = mk("load_195",         1, 0, 0, 0, 195,  0, 0, 195, 0, 0, 0);
        vecs[10] = mk("sat_up",           0, 1, 1, 0,   0,  7, 0, 200, 1, 0, 0);
        vecs[11] = mk("sat_up_again",     0, 1, 1, 0,   0,  7, 0, 200, 1, 0, 0);
        vecs[12] = mk("load_190",         1, 0, 0, 0, 190,  0, 0, 190, 0, 0, 0);
        vecs[13] = mk("up_exact_max",     0, 1, 1, 0,   0, 10, 0, 200, 1, 0, 0);
        vecs[14] = mk("wrap_up",          0, 1, 1, 0,   0,  1, 1,  10, 1, 0, 1);
        vecs[15] = mk("step0_at_min",     0, 1, 0, 1,   0,  0, 0,  10, 0, 0, 1);
        vecs[16] = mk("sat_dn",           0, 1, 0, 1,   0,  4, 0,  10, 0, 1, 1);
        vecs[17] = mk("load_12",          1, 0, 0, 0,  12,  0, 0,  12, 0, 0, 0);
        vecs[18] = mk("wrap_dn",          0, 1, 0, 1,   0,  5, 1, 200, 0, 1, 1);
        vecs[19] = mk("en0_up",           0, 0, 1, 0,   0,  5, 0, 200, 0, 0, 1);
        vecs[20] = mk("load_15",          1, 0, 0, 0,  15,  0, 0,  15, 0, 0, 0);
        vecs[21] = mk("dn_exact_min",     0, 1, 0, 1,   0,  5, 1,  10, 0, 1, 0);
        vecs[22] = mk("up_step15",        0, 1, 1, 0,   0, 15, 0,  25, 0, 0, 0);
        vecs[23] = mk("load_10",          1, 0, 0, 0,  10,  0, 0,  10, 0, 0, 0);
        vecs[24] = mk("wrap_dn_neg",      0, 1, 0, 1,   0, 15, 1, 200, 0, 1, 1);
        vecs[25] = mk("sat_up_big",       0, 1, 1, 0,   0, 15, 0, 200, 1, 0, 1);
        vecs[26] = mk("idle_hold",        0, 0, 0, 0,   0,  0, 0, 200, 0, 0, 1);
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] wc_model;

        // Reset state, checked while reset is still held.
        repeat (3) @(negedge CLK);
        expect_out(8'd10, 1'b0, 1'b0, 8'd0);
        check("reset_state");
        RST_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].en, vecs[i].up, vecs[i].dn,
                  vecs[i].in_v, vecs[i].st, vecs[i].wr);
            expect_out(vecs[i].e_cnt, vecs[i].e_tu, vecs[i].e_td, vecs[i].e_wc);
            cycle(vecs[i].name);
        end

        // Enable gate: Up with En low for several cycles changes nothing.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'(3 + k), 1'b0);
            expect_out(8'd200, 1'b0, 1'b0, 8'd1);
            cycle($sformatf("en0_cycle%0d", k));
        end

        // Random stepping in saturate mode stays inside the bounds.
        for (int k = 0; k < 6; k++) begin
            int s;
            s = $urandom_range(1, 15);
            drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd100, 4'd0, 1'b0);
            expect_out(8'd100, 1'b0, 1'b0, 8'd0);
            cycle("rnd_load");
            drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'(s), 1'b0);
            expect_out(8'(100 + s), 1'b0, 1'b0, 8'd0);
            cycle($sformatf("rnd_up_s%0d", s));
        end

        // Asynchronous reset in the middle of counting at 57.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd50, 4'd0, 1'b0);
        expect_out(8'd50, 1'b0, 1'b0, 8'd0);
        cycle("pre_rst_load");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'd7, 1'b0);
        expect_out(8'd57, 1'b0, 1'b0, 8'd0);
        cycle("pre_rst_up");
        #2;
        RST_n = 1'b0;
        #1;
        expect_out(8'd10, 1'b0, 1'b0, 8'd0);
        check("async_rst_57");
        @(posedge CLK);
        @(negedge CLK);
        expect_out(8'd10, 1'b0, 1'b0, 8'd0);
        check("rst_held");
        RST_n = 1'b1;
        expect_out(8'd17, 1'b0, 1'b0, 8'd0);
        cycle("resume_after_rst");

        // Reset while a terminal-count pulse is high clears it at once.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd195, 4'd0, 1'b0);
        expect_out(8'd195, 1'b0, 1'b0, 8'd0);
        cycle("pre_rst2_load");
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 4'd7, 1'b0);
        expect_out(8'd200, 1'b1, 1'b0, 8'd0);
        cycle("pre_rst2_tc");
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        #2;
        RST_n = 1'b0;
        #1;
        expect_out(8'd10, 1'b0, 1'b0, 8'd0);
        check("async_rst_tc");
        @(negedge CLK);
        RST_n = 1'b1;

`ifdef UDC_WRAP_CNT_EN
        // Wrap count saturates at 255: alternate up/down wraps between bounds.
        wc_model = 8'd0;
        for (int k = 0; k < 260; k++) begin
            logic go_up;
            go_up = (k % 2 == 0) ? 1'b0 : 1'b1;   // start at MIN, so go down first
            drive(1'b0, 1'b1, go_up, ~go_up, 8'd0, 4'd1, 1'b1);
            if (wc_model != 8'hFF) wc_model = wc_model + 8'd1;
            expect_out(go_up ? 8'd10 : 8'd200, go_up, ~go_up, wc_model);
            cycle($sformatf("wc_sat%0d", k));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd80, 4'd0, 1'b0);
        expect_out(8'd80, 1'b0, 1'b0, 8'd0);
        cycle("wc_load_clear");
`else
        wc_model = 8'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd80, 4'd0, 1'b0);
        expect_out(8'd80, 1'b0, 1'b0, wc_model);
        cycle("final_load");
`endif

        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "time limit");
    end

endmodule
